// File: rtl/pipe_credit_ctrl_pkg.sv
// Shared common header for the credit-controlled pipeline slice: default
// data width, the register-update delay macro and the credit-width helper.
`ifndef PIPE_CREDIT_COMMON_DEFS
`define PIPE_CREDIT_COMMON_DEFS
`define BIT_WIDTH 16
`define SD
`endif

package pipe_credit_ctrl_pkg;

   localparam int DEFAULT_LATENCY   = 4;
   localparam int DEFAULT_BUF_DEPTH = 8;

   // Credits run 0..depth inclusive, so one extra bit over the index width.
   function automatic int credit_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pipe_out_fifo.sv
// Synchronous output buffer: registered storage, no bypass, pointers carry
// one wrap bit so full and empty are distinguishable without a counter.
module pipe_out_fifo
   import pipe_credit_ctrl_pkg::*;
#(
   parameter int DEPTH = DEFAULT_BUF_DEPTH,
   parameter int WIDTH = `BIT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             wr_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;

   // Full/empty decode and the accepted read/write strobes.
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_wr   = wr_en && !full;
      do_rd   = rd_en && !empty;
      wr_drop = wr_en && full;
      rd_data = mem[rd_ptr[AW-1:0]];
   end

   // Storage needs no reset; only written slots are ever presented.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= `SD wr_data;
      end
   end

   // Pointer update; the natural binary wrap gives modulo-DEPTH indexing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= `SD wr_ptr + (AW+1)'(1);
         end
         if (do_rd) begin
            rd_ptr <= `SD rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/pipe_credit_ctrl.sv
// Credit-based flow control around a fixed-latency, non-stallable datapath.
// Each credit is one output-buffer slot; a word may only be issued when a
// slot is reserved for it, so the buffer can never overflow.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and up_ready is decoded from
// registered credits only (no combinational path from down_ready).
module pipe_credit_ctrl
   import pipe_credit_ctrl_pkg::*;
#(
   parameter int LATENCY   = DEFAULT_LATENCY,
   parameter int BIT_WIDTH = `BIT_WIDTH,
   parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  up_valid,
   output logic                                  up_ready,
   input  logic [BIT_WIDTH-1:0]                  up_data,
   output logic                                  pipe_in_valid,
   output logic [BIT_WIDTH-1:0]                  pipe_in,
   input  logic [BIT_WIDTH-1:0]                  pipe_out,
   output logic                                  down_valid,
   input  logic                                  down_ready,
   output logic [BIT_WIDTH-1:0]                  down_data,
   output logic [credit_width(BUF_DEPTH)-1:0]    credits,
   output logic                                  busy,
   output logic                                  ovf_err
);

   localparam int CW = credit_width(BUF_DEPTH);

   logic [CW-1:0]      credits_q;
   logic [LATENCY-1:0] valid_sr;
   logic               fire;
   logic               pop;
   logic               fifo_empty;
   logic               fifo_full;
   logic               fifo_drop;

   // Handshake decode; reset holds every strobe low.
   always_comb begin
      up_ready      = !rst && (credits_q != '0);
      fire          = up_valid && up_ready;
      pipe_in_valid = fire;
      pipe_in       = up_data;
      down_valid    = !fifo_empty;
      pop           = down_valid && down_ready;
      credits       = credits_q;
      busy          = (credits_q != CW'(BUF_DEPTH));
   end

   // Token tracker mirroring the datapath; the last stage marks pipe_out valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_sr <= '0;
      end else begin
         valid_sr[0] <= `SD fire;
         for (int i = 1; i < LATENCY; i++) begin
            valid_sr[i] <= `SD valid_sr[i-1];
         end
      end
   end

   // Credit accounting: issue consumes a slot, pop returns one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits_q <= CW'(BUF_DEPTH);
      end else if (fire && !pop && (credits_q != '0)) begin
         credits_q <= `SD credits_q - CW'(1);
      end else if (pop && !fire && (credits_q != CW'(BUF_DEPTH))) begin
         credits_q <= `SD credits_q + CW'(1);
      end
   end

   // Sticky record of any write that found the buffer full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_err <= 1'b0;
      end else if (fifo_drop) begin
         ovf_err <= `SD 1'b1;
      end
   end

   pipe_out_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (BIT_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (valid_sr[LATENCY-1]),
      .wr_data (pipe_out),
      .rd_en   (pop),
      .rd_data (down_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .wr_drop (fifo_drop)
   );

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// Bench for pipe_credit_ctrl with LATENCY=4, BUF_DEPTH=8, 16-bit data.
// The datapath is modelled as a plain 4-stage delay line.
module tb_pipe_credit_ctrl;

   localparam int LAT = 4;
   localparam int DEP = 8;
   localparam int W   = 16;
   localparam int CW  = 4;

   logic          clk;
   logic          rst;
   logic          up_valid;
   logic          up_ready;
   logic [W-1:0]  up_data;
   logic          pipe_in_valid;
   logic [W-1:0]  pipe_in;
   logic [W-1:0]  pipe_out;
   logic          down_valid;
   logic          down_ready;
   logic [W-1:0]  down_data;
   logic [CW-1:0] credits;
   logic          busy;
   logic          ovf_err;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  dp [LAT];
   int            n_cmp = 0;
   int            n_err = 0;

   pipe_credit_ctrl #(
      .LATENCY   (LAT),
      .BIT_WIDTH (W),
      .BUF_DEPTH (DEP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .up_valid      (up_valid),
      .up_ready      (up_ready),
      .up_data       (up_data),
      .pipe_in_valid (pipe_in_valid),
      .pipe_in       (pipe_in),
      .pipe_out      (pipe_out),
      .down_valid    (down_valid),
      .down_ready    (down_ready),
      .down_data     (down_data),
      .credits       (credits),
      .busy          (busy),
      .ovf_err       (ovf_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external datapath: identity with fixed latency
   always @(posedge clk) begin
      dp[0] <= pipe_in;
      for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
   end
   assign pipe_out = dp[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: accepted words are pushed, presented words are popped
   always @(negedge clk) begin
      if (!rst && up_valid && up_ready) exp_q.push_back(up_data);
      if (!rst && down_valid && down_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pop: got 0x%0h, expected no word at %0t", down_data, $time);
         end else begin
            check("pop_data", 32'(down_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      up_valid = 1'b0;
      up_data = '0;
      down_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_up_ready", 32'(up_ready), 0);
      check("rst_down_valid", 32'(down_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pipe_in_valid", 32'(pipe_in_valid), 0);
      check("rst_credits", 32'(credits), DEP);
      check("rst_ovf", 32'(ovf_err), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("release_up_ready", 32'(up_ready), 1);

      // single word
      for (int c = 0; c < 8; c++) begin
         tick();
         down_ready = 1'b1;
         up_valid = (c == 0);
         up_data = (c == 0) ? 16'h1234 : 16'h0000;
         @(negedge clk);
         if (c == 0) begin
            check("single_fire", 32'(pipe_in_valid), 1);
            check("single_pipe_in", 32'(pipe_in), 32'h1234);
         end
         if (c == 1) begin
            check("single_credits_taken", 32'(credits), 7);
            check("single_busy", 32'(busy), 1);
         end
         if (c >= 1 && c <= 4) check("single_no_early", 32'(down_valid), 0);
         if (c == 5) check("single_down_valid", 32'(down_valid), 1);
         if (c == 6) begin
            check("single_credits_back", 32'(credits), DEP);
            check("single_idle", 32'(busy), 0);
         end
      end

      // backpressure: fill every credit, then keep requesting
      for (int c = 0; c < 11; c++) begin
         tick();
         down_ready = 1'b0;
         up_valid = 1'b1;
         up_data = (c < 8) ? 16'(c + 1) : 16'h0009;
         @(negedge clk);
         if (c < 8) check("bp_up_ready", 32'(up_ready), 1);
         else check("bp_stall", 32'(up_ready), 0);
         if (c == 8) check("bp_credits_zero", 32'(credits), 0);
      end
      for (int c = 0; c < 6; c++) begin
         tick();
         up_valid = 1'b0;
         @(negedge clk);
      end
      check("bp_full_valid", 32'(down_valid), 1);
      check("bp_full_credits", 32'(credits), 0);
      for (int c = 0; c < 8; c++) begin
         tick();
         down_ready = 1'b1;
         @(negedge clk);
         check("bp_drain_valid", 32'(down_valid), 1);
      end
      tick();
      @(negedge clk);
      check("bp_empty", 32'(down_valid), 0);
      check("bp_credits_back", 32'(credits), DEP);
      check("bp_ovf", 32'(ovf_err), 0);

      // streaming with simultaneous fire and pop
      for (int c = 0; c < 100; c++) begin
         tick();
         up_valid = 1'b1;
         down_ready = 1'b1;
         up_data = 16'h0100 + 16'(c);
         @(negedge clk);
         if (c >= 5) begin
            check("stream_valid", 32'(down_valid), 1);
            check("stream_credits", 32'(credits), 3);
         end
         if (c == 50) check("simul_both", 32'(up_ready && down_valid), 1);
         if (c == 51) check("simul_credits_held", 32'(credits), 3);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         up_valid = 1'b0;
         @(negedge clk);
      end
      check("stream_drained", 32'(down_valid), 0);
      check("stream_credits_back", 32'(credits), DEP);

      // reset with three words in flight
      for (int c = 0; c < 3; c++) begin
         tick();
         up_valid = 1'b1;
         up_data = 16'h00A0 + 16'(c);
         @(negedge clk);
      end
      tick();
      up_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_down_valid", 32'(down_valid), 0);
      check("mid_rst_credits", 32'(credits), DEP);
      check("mid_rst_up_ready", 32'(up_ready), 0);
      for (int c = 0; c < 10; c++) begin
         tick();
         rst = 1'b0;
         @(negedge clk);
         check("post_rst_no_stale", 32'(down_valid), 0);
      end

      // clean traffic after reset
      for (int c = 0; c < 8; c++) begin
         tick();
         up_valid = (c == 0);
         up_data = 16'hBEEF;
         @(negedge clk);
         if (c == 5) check("post_rst_word", 32'(down_valid), 1);
      end
      check("final_credits", 32'(credits), DEP);
      check("final_ovf", 32'(ovf_err), 0);
      check("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_credit_ctrl.md
PIPE_CREDIT_CTRL -- requirements
Module: pipe_credit_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4: fixed cycle latency of the external non-stallable datapath pipeline; legal range 1..32.
REQ-002 SHALL have parameter BIT_WIDTH, default `BIT_WIDTH: data width in bits.
REQ-003 SHALL have parameter BUF_DEPTH, default 8: output buffer entries and total credits; power of 2; at least LATENCY+1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 up_valid  in  1  upstream has a data word.
REQ-007 up_ready  out  1  controller accepts the word this cycle.
REQ-008 up_data  in  BIT_WIDTH  upstream word.
REQ-009 pipe_in_valid  out  1  issue strobe into the datapath.
REQ-010 pipe_in  out  BIT_WIDTH  word sent to the datapath.
REQ-011 pipe_out  in  BIT_WIDTH  datapath result, LATENCY cycles after issue.
REQ-012 down_valid  out  1  buffer head is valid.
REQ-013 down_ready  in  1  downstream accepts the head.
REQ-014 down_data  out  BIT_WIDTH  buffer head word.
REQ-015 credits  out  clog2(BUF_DEPTH)+1  free credits.
REQ-016 busy  out  1  any token is in flight or buffered.
REQ-017 ovf_err  out  1  sticky flag: a write was attempted into a full buffer.

Function
REQ-018 fire = up_valid & up_ready; pop = down_valid & down_ready.
REQ-019 up_ready SHALL be (credits != 0), decoded from registered state only, with no combinational path from down_ready.
REQ-020 pipe_in SHALL equal up_data combinationally; pipe_in_valid SHALL equal fire.
REQ-021 A LATENCY-deep valid shift register SHALL track issued tokens; its last stage marks pipe_out as valid.
REQ-022 When the last valid stage is set, pipe_out SHALL be written into the output FIFO that same cycle.
REQ-023 The FIFO SHALL have no bypass: down_valid rises LATENCY+1 cycles after fire.
REQ-024 down_valid = FIFO not empty; down_data = FIFO head; pop advances the head.
REQ-025 FIFO read and write pointers SHALL wrap modulo BUF_DEPTH.
REQ-026 Ordering SHALL be strictly in order; no word dropped or duplicated.
REQ-027 Credit update per cycle:
- fire only: credits decrements by 1.
- pop only: credits increments by 1.
- fire and pop together: credits unchanged.
- neither: credits held.
REQ-028 credits SHALL never go below 0 or above BUF_DEPTH.
REQ-029 A FIFO write while full SHALL set ovf_err, drop the word and leave the FIFO unchanged; by construction this is unreachable.
REQ-030 busy = (credits != BUF_DEPTH).
REQ-031 Sustained throughput with down_ready held at 1 SHALL be 1 word per cycle.

Reset
REQ-032 rst SHALL asynchronously force:
- all valid stages to 0;
- FIFO pointers to empty;
- credits to BUF_DEPTH;
- ovf_err to 0.
REQ-033 While rst is high: up_ready=0, pipe_in_valid=0, down_valid=0, busy=0.
REQ-034 Tokens in flight at reset SHALL be discarded; no stale word SHALL appear after release.
REQ-035 Data registers (FIFO storage) need no reset.

Structure
REQ-036 The BIT_WIDTH default and the `SD delay macro SHALL come from the shared common header.
REQ-037 The credit-width helper function SHALL live in the shared common header.
REQ-038 The output buffer SHALL be one sub-module, pipe_out_fifo, a synchronous FIFO with parameters DEPTH and WIDTH.

Verification (LATENCY=4, BUF_DEPTH=8)
REQ-039 Single word: fire 0x1234 at cycle 0, down_ready=1 -> down_valid and down_data=0x1234 at cycle 5; credits back to 8 at cycle 6; busy low at cycle 6.
REQ-040 Backpressure: down_ready=0, fire 8 words 0x1..0x8 -> up_ready=0 after the 8th fire, credits=0; then down_ready=1 -> 8 pops in order 0x1..0x8; credits=8; ovf_err=0.
REQ-041 Streaming: up_valid=1 and down_ready=1 for 100 cycles -> one pop per cycle after the 5-cycle fill; credits steady at 3.
REQ-042 Simultaneous: at credits=3, fire and pop in the same cycle -> credits remains 3 next cycle.
REQ-043 Reset mid-flight: 3 words in flight, rst pulsed for 1 cycle -> down_valid=0 immediately and credits=8; no down_valid for 10 cycles after release.
